// File: rtl/jk_modn_counter_if.sv
// jk_modn_counter_if: control inputs and observable outputs of the JK modulo-N counter
interface jk_modn_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] j_vec;
   logic [WIDTH-1:0] k_vec;
   logic             tc;
   logic             wrap;
   logic             load_err;
   modport master (
      output en, up_dn, load, load_val,
      input  q, j_vec, k_vec, tc, wrap, load_err
   );
   modport slave (
      input  en, up_dn, load, load_val,
      output q, j_vec, k_vec, tc, wrap, load_err
   );
endinterface

// File: rtl/jk_modn_counter.sv
// jk_modn_counter: modulo-N up/down counter whose state bits are JK cells
// driven by excitation terms derived from the desired next count.
module jk_modn_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input logic              clk,
   input logic              rst_n,
   jk_modn_counter_if.slave bus
);
   if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_modulus
      $error("jk_modn_counter: MODULUS must lie in 2..2**WIDTH");
   end
   // one extra bit so MODULUS = 2**WIDTH still compares correctly
   localparam logic [WIDTH:0] TOP = (WIDTH + 1)'(MODULUS - 1);
   logic [WIDTH-1:0] q, nxt, j, k;
   logic [WIDTH:0]   qx, lvx;
   logic             lv_ok, tc, wrap, load_err;
   assign qx    = {1'b0, q};
   assign lvx   = {1'b0, bus.load_val};
   assign lv_ok = lvx <= TOP;
   always_comb begin
      nxt = bus.load    ? (lv_ok ? bus.load_val : '0)
          : !bus.en     ? q
          : bus.up_dn   ? (qx == TOP ? '0 : WIDTH'(qx + 1'b1))
          : (qx == '0 ? TOP[WIDTH-1:0] : WIDTH'(qx - 1'b1));
   end
   assign j  = ~q & nxt;
   assign k  = q & ~nxt;
   assign tc = bus.en & ~bus.load & (bus.up_dn ? qx == TOP : qx == '0);
   // each bit obeys the JK rule: 00 hold, 01 clear, 10 set, 11 toggle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q        <= '0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         for (int i = 0; i < WIDTH; i++)
            q[i] <= j[i] & k[i] ? ~q[i] : j[i] ? 1'b1 : k[i] ? 1'b0 : q[i];
         wrap     <= tc;
         load_err <= bus.load ? ~lv_ok : load_err;
      end
   end
   assign bus.q        = q;
   assign bus.j_vec    = j;
   assign bus.k_vec    = k;
   assign bus.tc       = tc;
   assign bus.wrap     = wrap;
   assign bus.load_err = load_err;
endmodule

// File: tb/tb_jk_modn_counter.sv
// tb_jk_modn_counter: directed stimulus against an arithmetic reference model
// for a mod-10 (4-bit) and a mod-8 (3-bit) instance.
module tb_jk_modn_counter;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   jk_modn_counter_if #(.WIDTH(4)) a_if ();
   jk_modn_counter_if #(.WIDTH(3)) b_if ();
   jk_modn_counter #(.WIDTH(4), .MODULUS(10)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
   jk_modn_counter #(.WIDTH(3), .MODULUS(8))  u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
      end
   endtask
   // reference: the counter as plain modular arithmetic on integers
   function automatic int f_nxt(int q, bit en, bit ud, bit ld, int lv, int m);
      if (ld) return (lv < m) ? lv : 0;
      if (en) return ud ? (q + 1) % m : (q + m - 1) % m;
      return q;
   endfunction
   function automatic bit f_tc(int q, bit en, bit ud, bit ld, int m);
      return en && !ld && (ud ? q == m - 1 : q == 0);
   endfunction
   int ma_q = 0, mb_q = 0;
   bit ma_w = 0, mb_w = 0, ma_e = 0, mb_e = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma_q = 0; ma_w = 0; ma_e = 0;
         mb_q = 0; mb_w = 0; mb_e = 0;
      end else begin
         ma_w = f_tc(ma_q, a_if.en, a_if.up_dn, a_if.load, 10);
         ma_e = a_if.load ? (int'(a_if.load_val) >= 10) : ma_e;
         ma_q = f_nxt(ma_q, a_if.en, a_if.up_dn, a_if.load, int'(a_if.load_val), 10);
         mb_w = f_tc(mb_q, b_if.en, b_if.up_dn, b_if.load, 8);
         mb_e = b_if.load ? (int'(b_if.load_val) >= 8) : mb_e;
         mb_q = f_nxt(mb_q, b_if.en, b_if.up_dn, b_if.load, int'(b_if.load_val), 8);
      end
   end
   always @(negedge clk) begin
      int na, nb;
      na = f_nxt(ma_q, a_if.en, a_if.up_dn, a_if.load, int'(a_if.load_val), 10);
      nb = f_nxt(mb_q, b_if.en, b_if.up_dn, b_if.load, int'(b_if.load_val), 8);
      chk("a_q",    a_if.q, ma_q);
      chk("a_tc",   a_if.tc, f_tc(ma_q, a_if.en, a_if.up_dn, a_if.load, 10));
      chk("a_wrap", a_if.wrap, ma_w);
      chk("a_err",  a_if.load_err, ma_e);
      chk("a_j",    a_if.j_vec, ~ma_q & na & 15);
      chk("a_k",    a_if.k_vec, ma_q & ~na & 15);
      chk("b_q",    b_if.q, mb_q);
      chk("b_tc",   b_if.tc, f_tc(mb_q, b_if.en, b_if.up_dn, b_if.load, 8));
      chk("b_wrap", b_if.wrap, mb_w);
      chk("b_err",  b_if.load_err, mb_e);
      chk("b_j",    b_if.j_vec, ~mb_q & nb & 7);
      chk("b_k",    b_if.k_vec, mb_q & ~nb & 7);
   end
   task automatic set_a(input bit e, input bit ud, input bit ld, input logic [3:0] lv);
      a_if.en = e; a_if.up_dn = ud; a_if.load = ld; a_if.load_val = lv;
   endtask
   task automatic drive_a(input bit e, input bit ud, input bit ld, input logic [3:0] lv);
      set_a(e, ud, ld, lv);
      @(posedge clk);
      #1;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end
   initial begin
      rst_n = 1'b0;
      set_a(0, 0, 0, 0);
      b_if.en = 0; b_if.up_dn = 0; b_if.load = 0; b_if.load_val = 0;
      #1;
      chk("rst_q", a_if.q, 0);
      chk("rst_wrap", a_if.wrap, 0);
      chk("rst_err", a_if.load_err, 0);
      chk("rst_jk", {a_if.j_vec, a_if.k_vec}, 0);
      chk("rst_tc", a_if.tc, 0);
      #11 rst_n = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         drive_a(1, 1, 0, 0);
         chk("up_seq", a_if.q, i % 10);
         chk("up_jk_excl", a_if.j_vec & a_if.k_vec, 0);
         if (i == 9) chk("up_tc9", a_if.tc, 1);
         if (i == 10) chk("up_wrap0", a_if.wrap, 1);
      end
      drive_a(0, 0, 1, 3);
      chk("ld3", a_if.q, 3);
      for (int i = 1; i <= 5; i++) begin
         drive_a(1, 0, 0, 0);
         chk("dn_seq", a_if.q, (13 - i) % 10);
         if (i == 3) begin
            chk("dn_tc0", a_if.tc, 1);
            chk("dn_j", a_if.j_vec, 4'b1001);
            chk("dn_k", a_if.k_vec, 0);
         end
      end
      drive_a(0, 0, 1, 12);
      chk("oor_q", a_if.q, 0);
      chk("oor_err", a_if.load_err, 1);
      for (int i = 1; i <= 3; i++) begin
         drive_a(1, 1, 0, 0);
         chk("err_hold", a_if.load_err, 1);
      end
      drive_a(0, 0, 1, 5);
      chk("ld5_q", a_if.q, 5);
      chk("ld5_err", a_if.load_err, 0);
      drive_a(0, 1, 1, 9);
      set_a(1, 1, 1, 2);
      #1;
      chk("ldwin_tc", a_if.tc, 0);
      @(posedge clk);
      #1;
      chk("ldwin_q", a_if.q, 2);
      chk("ldwin_wrap", a_if.wrap, 0);
      drive_a(0, 1, 0, 0);
      chk("hold_q", a_if.q, 2);
      chk("hold_wrap", a_if.wrap, 0);
      chk("hold_jk", {a_if.j_vec, a_if.k_vec}, 0);
      drive_a(0, 0, 1, 7);
      set_a(1, 1, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_q", a_if.q, 0);
      chk("arst_wrap", a_if.wrap, 0);
      chk("arst_err", a_if.load_err, 0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("resume_q", a_if.q, 1);
      set_a(0, 0, 0, 0);
      b_if.en = 1; b_if.up_dn = 1;
      for (int i = 1; i <= 9; i++) begin
         @(posedge clk);
         #1;
         chk("b_seq", b_if.q, i % 8);
         if (i == 7) begin
            chk("b_tc7", b_if.tc, 1);
            chk("b_wrap_j", b_if.j_vec, 0);
            chk("b_wrap_k", b_if.k_vec, 3'b111);
         end
         if (i == 8) chk("b_wrap0", b_if.wrap, 1);
      end
      b_if.en = 0;
      @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/jk_modn_counter.md
# jk_modn_counter

Synchronous modulo-N up/down counter whose every state bit is a JK cell driven by generated excitation (J/K) terms. It consumes the JK flip-flop behaviour directly downstream of the JK and master-slave stages. It provides the divide-by-N, terminal-count and wrap outputs used by the counter and sequencer exercises that follow. J/K vectors are exported so the bench can check the excitation logic independently of the state.

## Interface

Parameters:
- `WIDTH`, default 4: state width in bits.
- `MODULUS`, default 10: count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH; any other value is an elaboration error.

Ports:
- `clk`, input, 1: single clock, rising-edge active.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: count enable.
- `up_dn`, input, 1: direction, 1 = up, 0 = down.
- `load`, input, 1: synchronous parallel load; has priority over `en`.
- `load_val`, input, WIDTH: value to load.
- `q`, output, WIDTH: current count, registered.
- `j_vec`, output, WIDTH: per-bit J excitation, combinational.
- `k_vec`, output, WIDTH: per-bit K excitation, combinational.
- `tc`, output, 1: terminal count, combinational.
- `wrap`, output, 1: one-cycle registered pulse after a wrap.
- `load_err`, output, 1: sticky flag set by an out-of-range load.

## Operation

- State is held in WIDTH JK cells. The only legal update rule per bit is: 00 hold, 01 clear, 10 set, 11 toggle. No direct D-style assignment of `q` is allowed outside reset.
- The next-state value `nxt` is chosen in priority order:
  - `load`=1, `load_val` < MODULUS: `nxt` = `load_val`.
  - `load`=1, `load_val` >= MODULUS: `nxt` = 0, and `load_err` is set.
  - `en`=1, `up_dn`=1: `nxt` = (`q` == MODULUS-1) ? 0 : `q`+1.
  - `en`=1, `up_dn`=0: `nxt` = (`q` == 0) ? MODULUS-1 : `q`-1.
  - otherwise: `nxt` = `q`.
- Excitation per bit i: `j_vec[i]` = ~q[i] & nxt[i], and `k_vec[i]` = q[i] & ~nxt[i]. The minimal-form 11 (toggle) encoding is never produced, so J and K are never both 1 on the same bit.
- `tc` = `en` & ~`load` & (`up_dn` ? (`q` == MODULUS-1) : (`q` == 0)).
- `wrap` is a registered copy of `tc`: it is high for exactly the one cycle after a wrapping edge.
- `load_err` is set on any out-of-range load and cleared by the next in-range load. It is otherwise held; `en` has no effect on it.
- Arithmetic is done at WIDTH+1 bits internally, so MODULUS = 2**WIDTH compares correctly.

## Timing

- Reset (`rst_n`=0, asynchronous): `q`=0, `wrap`=0, `load_err`=0 immediately, without waiting for a clock edge. With the inputs idle, `j_vec`=0, `k_vec`=0 and `tc`=0.
- Reset release is seen synchronously. The first count occurs on the first rising edge after `rst_n` goes high with `en`=1.
- Latency:
  - `q` reflects `nxt` one rising edge after inputs are sampled.
  - `j_vec`, `k_vec` and `tc` follow inputs and `q` combinationally, within the same cycle.
  - `wrap` lags `tc` by one cycle.
- Simultaneous events:
  - `load` with `en`: load wins, and `tc`/`wrap` are suppressed.
  - A direction change at the terminal state takes effect in the same cycle, because `tc` uses the current `up_dn`.
- Reset mid-count: `q` returns to 0 asynchronously. A `wrap` pulse in flight is cleared.
- `en`=0 with `load`=0: `q` holds, `j_vec`=`k_vec`=0, and `tc`=0 regardless of `q`.

## Test plan

- Reset, then `en`=1, `up_dn`=1 for 12 cycles with the default parameters. `q` must read 1..9, 0, 1, 2. `tc` is high while `q`=9, `wrap` is high in the cycle `q`=0, and `j_vec` & `k_vec` = 0 every cycle.
- `load`=1, `load_val`=3, then count down for 5 cycles. `q` must read 3, 2, 1, 0, 9, 8. `tc` is high at `q`=0. At the 0→9 edge, `j_vec`=4'b1001 and `k_vec`=0.
- `load_val`=12 with `load`=1. Result must be `q`=0 and `load_err`=1. `load_err` must stay high while counting, then clear after `load_val`=5 (giving `q`=5).
- `q`=9 with `load`=1, `load_val`=2 and `en`=1 in the same cycle. Result must be `q`=2 next, with `tc`=0 and `wrap` never asserted.
- `rst_n` pulsed low mid-cycle at `q`=7. `q`=0, `wrap`=0 and `load_err`=0 must follow immediately, before the next edge. Counting must resume at 1 on the first edge after release.
- `WIDTH`=3, `MODULUS`=8, up for 9 cycles. `q` must wrap 7→0, with `j_vec`=0 and `k_vec`=3'b111 on the wrap cycle.
